// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into edge, short, long and double press pulses
// Also keeps a wrapping count of presses (rising edges).
module button_event_decoder #(
  parameter int TICK_DIV   = 4,
  parameter int LONG_TICKS = 8,
  parameter int DBL_TICKS  = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             db_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic             short_o,
  output logic             long_o,
  output logic             double_o,
  output logic [CNT_W-1:0] press_cnt_o
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;
  localparam logic [CNT_W-1:0] LONG_T    = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] DBL_T     = CNT_W'(DBL_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             db_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, fall_q, short_q, long_q, double_q;
  logic             short_d, long_d, double_d;
  logic             rise, fall, tick, long_hit, dbl_hit;

  assign rise = db_i & ~db_q;
  assign fall = ~db_i & db_q;
  assign tick = (pre_q == PRE_LAST);

  // Thresholds look at the value the timer is about to take, so a threshold of
  // K fires on the edge exactly K*TICK_DIV cycles after state entry.
  assign timer_inc = (tick && (timer_q != TIMER_MAX)) ? timer_q + CNT_W'(1) : timer_q;
  assign long_hit  = (timer_inc == LONG_T);
  assign dbl_hit   = (timer_inc == DBL_T);
  assign cnt_d     = cnt_q + CNT_W'(rise);

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d = ST_WAIT2;
        end else if (long_hit) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (dbl_hit) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end else if (long_hit) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (fall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      pre_d   = '0;
      timer_d = '0;
    end else begin
      pre_d   = tick ? '0 : pre_q + PRE_W'(1);
      timer_d = timer_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      db_q     <= 1'b0;
      pre_q    <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      db_q     <= db_i;
      pre_q    <= pre_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise;
      fall_q   <= fall;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign short_o     = short_q;
  assign long_o      = long_q;
  assign double_o    = double_q;
  assign press_cnt_o = cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
// Reference model tracks gesture phase and elapsed cycles since phase entry.
module tb_button_event_decoder;

  localparam int TICK_DIV   = 4;
  localparam int LONG_TICKS = 8;
  localparam int DBL_TICKS  = 4;
  localparam int CNT_W      = 8;
  localparam int LONG_CYC   = LONG_TICKS * TICK_DIV;
  localparam int DBL_CYC    = DBL_TICKS * TICK_DIV;
  localparam int VW         = CNT_W + 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             db_i;
  logic             rise_o, fall_o, short_o, long_o, double_o;
  logic [CNT_W-1:0] press_cnt_o;

  button_event_decoder #(
    .TICK_DIV(TICK_DIV), .LONG_TICKS(LONG_TICKS), .DBL_TICKS(DBL_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .db_i(db_i),
    .rise_o(rise_o), .fall_o(fall_o), .short_o(short_o), .long_o(long_o),
    .double_o(double_o), .press_cnt_o(press_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {PH_IDLE, PH_DOWN1, PH_GAP, PH_DOWN2, PH_HELD} phase_e;
  phase_e        m_phase;
  int            m_elapsed;
  logic          m_prev;
  int            m_cnt;
  logic [VW-1:0] exp_q[$];

  int            checks = 0;
  int            failures = 0;
  bit            mon_en = 1'b0;
  int            obs_short, obs_long, obs_double, obs_dbl_fall;
  logic [VW-1:0] mon_got, mon_exp;

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_elapsed = 0;
    m_prev    = 1'b0;
    m_cnt     = 0;
  endtask

  // One clock edge of the gesture rules, sampling level d.
  task automatic model_step(input logic d);
    logic r, f, s, l, dd;
    int   el;
    phase_e nxt;
    r = d & ~m_prev;
    f = ~d & m_prev;
    s = 1'b0; l = 1'b0; dd = 1'b0;
    el  = m_elapsed + 1;
    nxt = m_phase;
    case (m_phase)
      PH_IDLE:  if (r) nxt = PH_DOWN1;
      PH_DOWN1: if (f) nxt = PH_GAP;
                else if (el == LONG_CYC) begin nxt = PH_HELD; l = 1'b1; end
      PH_GAP:   if (r) nxt = PH_DOWN2;
                else if (el == DBL_CYC) begin nxt = PH_IDLE; s = 1'b1; end
      PH_DOWN2: if (f) begin nxt = PH_IDLE; dd = 1'b1; end
                else if (el == LONG_CYC) begin nxt = PH_HELD; l = 1'b1; end
      PH_HELD:  if (f) nxt = PH_IDLE;
      default:  nxt = PH_IDLE;
    endcase
    m_elapsed = (nxt != m_phase) ? 0 : el;
    m_phase   = nxt;
    m_prev    = d;
    m_cnt     = (m_cnt + int'(r)) % (1 << CNT_W);
    exp_q.push_back({r, f, s, l, dd, CNT_W'(m_cnt)});
  endtask

  task automatic hold(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      db_i = lvl;
      model_step(lvl);
      @(negedge clk_i);
    end
  endtask

  task automatic clear_obs();
    obs_short = 0; obs_long = 0; obs_double = 0; obs_dbl_fall = 0;
  endtask

  // Entered at a negedge; reset lands mid-cycle and is checked before the next edge.
  task automatic do_reset(input logic lvl);
    mon_en = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_rise", int'(rise_o), 0);
    check_val("rst_fall", int'(fall_o), 0);
    check_val("rst_short", int'(short_o), 0);
    check_val("rst_long", int'(long_o), 0);
    check_val("rst_double", int'(double_o), 0);
    check_val("rst_cnt", int'(press_cnt_o), 0);
    db_i = lvl;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_q.delete();
    model_reset();
    clear_obs();
    mon_en = 1'b1;
  endtask

  task automatic expect_counts(input string name, input int s, input int l, input int d);
    check_val({name, "_short"}, obs_short, s);
    check_val({name, "_long"}, obs_long, l);
    check_val({name, "_double"}, obs_double, d);
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en) begin
        mon_got = {rise_o, fall_o, short_o, long_o, double_o, press_cnt_o};
        obs_short    += int'(short_o);
        obs_long     += int'(long_o);
        obs_double   += int'(double_o);
        obs_dbl_fall += int'(double_o & fall_o);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got=%b t=%0t", mon_got, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL cycle_out got=%b exp=%b (rise,fall,short,long,double,cnt) t=%0t",
                     mon_got, mon_exp, $time);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lvl;
    int   sel, dur;
    rst_ni = 1'b1;
    db_i   = 1'b0;
    model_reset();
    clear_obs();
    @(negedge clk_i);

    do_reset(1'b0);
    hold(1'b1, 10); hold(1'b0, 30);
    expect_counts("short_press", 1, 0, 0);
    check_val("short_press_cnt", int'(press_cnt_o), 1);

    do_reset(1'b0);
    hold(1'b1, 40); hold(1'b0, 30);
    expect_counts("long_press", 0, 1, 0);

    do_reset(1'b0);
    hold(1'b1, 6); hold(1'b0, 5); hold(1'b1, 6); hold(1'b0, 30);
    expect_counts("double_press", 0, 0, 1);
    check_val("double_with_fall", obs_dbl_fall, 1);
    check_val("double_press_cnt", int'(press_cnt_o), 2);

    do_reset(1'b0);
    hold(1'b1, 6); hold(1'b0, 20); hold(1'b1, 6); hold(1'b0, 30);
    expect_counts("slow_second", 2, 0, 0);

    do_reset(1'b0);
    hold(1'b1, 6); hold(1'b0, DBL_CYC); hold(1'b1, 6); hold(1'b0, 30);
    expect_counts("race_rise_timeout", 0, 0, 1);

    do_reset(1'b0);
    hold(1'b1, LONG_CYC); hold(1'b0, 30);
    expect_counts("race_fall_long", 1, 0, 0);

    do_reset(1'b0);
    hold(1'b1, 6); hold(1'b0, 5); hold(1'b1, 3);
    do_reset(1'b0);
    hold(1'b1, 10); hold(1'b0, 30);
    expect_counts("after_mid_reset", 1, 0, 0);
    check_val("after_mid_reset_cnt", int'(press_cnt_o), 1);

    do_reset(1'b1);
    hold(1'b1, 10); hold(1'b0, 30);
    expect_counts("high_at_release", 1, 0, 0);

    do_reset(1'b0);
    for (int i = 0; i < 256; i++) begin
      hold(1'b1, 1); hold(1'b0, 1);
    end
    hold(1'b0, 20);
    check_val("wrap_cnt", int'(press_cnt_o), 0);

    lvl = 1'b1;
    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: dur = 1;
        1: dur = DBL_CYC - 1;
        2: dur = DBL_CYC;
        3: dur = DBL_CYC + 1;
        4: dur = LONG_CYC - 1;
        5: dur = LONG_CYC;
        6: dur = LONG_CYC + 1;
        default: dur = int'($urandom_range(1, 45));
      endcase
      if ($urandom_range(0, 24) == 0) do_reset(lvl);
      hold(lvl, dur);
      lvl = ~lvl;
    end
    hold(1'b0, 40);

    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Downstream consumer of the debounced switch level (`db_o` of the debouncer).
- Turns the clean level into one-cycle event pulses:
  - rise and fall edges,
  - short press, long press, double press.
- Also keeps a wrapping press counter.
- Sits between the debouncer and the control logic / LED and UI logic that react to button gestures.

Parameters:
- TICK_DIV, 4, clock cycles per timing tick (≥2).
- LONG_TICKS, 8, ticks a press must be held to count as long (≥1).
- DBL_TICKS, 4, maximum release gap, in ticks, for a second press to count as a double (≥1).
- CNT_W, 8, width of the tick timer and of `press_cnt_o`. Must hold LONG_TICKS and DBL_TICKS.

Ports:
- clk_i  input  1  system clock, rising-edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- db_i  input  1  debounced switch level, synchronous to `clk_i`.
- rise_o  output  1  one-cycle pulse on a 0→1 edge of `db_i`.
- fall_o  output  1  one-cycle pulse on a 1→0 edge of `db_i`.
- short_o  output  1  one-cycle pulse: single short press confirmed.
- long_o  output  1  one-cycle pulse: long-press threshold reached.
- double_o  output  1  one-cycle pulse: double press completed.
- press_cnt_o  output  CNT_W  count of rising edges, wraps modulo 2^CNT_W.

Behaviour:
Reset (rst_ni=0, asynchronous):
- state=IDLE, db_q=0, prescaler=0, timer=0.
- All outputs 0, press_cnt_o=0.

Edge detection:
- db_q registers db_i every cycle.
- rise = db_i & ~db_q; fall = ~db_i & db_q.
- rise_o and fall_o are registered. They go high in the cycle after the edge that samples the level change.
- press_cnt_o increments by 1 at the same edge rise is seen, in any state.

Timing:
- Prescaler counts 0..TICK_DIV-1 and wraps. tick = (prescaler == TICK_DIV-1).
- Timer increments on each tick and saturates at 2^CNT_W-1.
- Prescaler and timer both clear on every state transition, so the timer reaches K exactly K*TICK_DIV cycles after state entry.

FSM states:
- IDLE
  - rise → PRESS1.
- PRESS1
  - fall → WAIT2.
  - else timer==LONG_TICKS → LONG_HELD, pulse long_o.
- WAIT2
  - rise → PRESS2.
  - else timer==DBL_TICKS → IDLE, pulse short_o.
- PRESS2
  - fall → IDLE, pulse double_o.
  - else timer==LONG_TICKS → LONG_HELD, pulse long_o. No double_o is issued for this gesture.
- LONG_HELD
  - fall → IDLE. No event pulse.
- Unreachable encodings → IDLE.

Event pulses:
- short_o, long_o and double_o are registered. Each is high for exactly 1 cycle, in the cycle after the transition edge.
- At most one of short_o, long_o and double_o is high in any cycle.

Simultaneous events and boundaries:
- PRESS1/PRESS2: fall and the timer threshold in the same cycle → fall wins.
- WAIT2: rise and timeout in the same cycle → rise wins (double path).
- rise_o/fall_o may coincide with a gesture pulse. Example: fall_o and double_o are both high in the same cycle.
- Reset asserted mid-gesture discards the gesture with no pulse, and clears press_cnt_o.
- After reset release, db_q=0. If db_i=1 at release, the first edge is treated as a rise.

Test Plan:
Test Plan values use TICK_DIV=4, LONG_TICKS=8, DBL_TICKS=4, CNT_W=8. Edge 0 is the edge that samples db_i=1.
1. Short press: db_i high 10 cycles, then low and held low.
   - rise_o at cycle 1; fall_o one cycle after the fall is sampled.
   - short_o exactly 17 cycles after the fall-sampling edge (16 cycles in WAIT2 plus 1 cycle of registering).
   - press_cnt_o=1; no long_o or double_o.
2. Long press: db_i high 40 cycles.
   - long_o high in the cycle after edge 32.
   - On release: fall_o only, no short_o; state returns to IDLE.
3. Double press: high 6, low 5, high 6, low.
   - double_o coincides with the second fall_o.
   - press_cnt_o=2; no short_o.
4. Slow second press: high 6, low 20, high 6, low.
   - First short_o at 16 cycles into the gap (plus 1 cycle of registering).
   - Second press yields a second short_o after its own 16-cycle gap; no double_o.
5. Race: release gap sized so the rise is sampled at the exact timeout edge.
   - Result is the double path; no short_o.
   - Same check for fall at edge 32 of PRESS1: WAIT2 entered, no long_o.
6. Reset mid-PRESS2: assert rst_ni=0 asynchronously.
   - All outputs 0 immediately and press_cnt_o=0.
   - After release, no stale pulse; the next short press decodes normally.
   - Wrap: 256 presses leave press_cnt_o=0.
